// File: rtl/ddl_event_packer.sv
// Splits 32-bit event words into 17-bit DDL FIFO writes and
// closes each event with a two-word DTSTW marker (bit 16 set).
module ddl_event_packer #(
  parameter logic [19:0] MAX_WORDS = 20'd262143,
  parameter logic [7:0]  STW_ID    = 8'h82
) (
  input  logic        wr_clk,
  input  logic        reset,
  input  logic [31:0] ev_data,
  input  logic        ev_valid,
  input  logic        ev_sof,
  input  logic        ev_eof,
  output logic        ev_ready,
  output logic        wr_en,
  output logic [16:0] din,
  input  logic        full,
  input  logic        prog_full,
  output logic        ev_busy,
  output logic [15:0] events_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_LO,
    S_HI,
    S_STW_H,
    S_STW_L
  } st_t;

  st_t         st;
  logic [31:0] word;
  logic        eof_q;
  logic        err;
  logic [18:0] len;
  logic [3:0]  tid;
  logic        xfer;
  logic [18:0] len_now;
  logic [31:0] dtstw;

  assign ev_ready = (st == S_IDLE || st == S_OPEN)
                  && !prog_full && !reset;
  assign xfer     = ev_valid && ev_ready;
  assign dtstw    = {err, len, tid, STW_ID};
  // a new event starts counting from zero
  assign len_now  = (st == S_IDLE) ? '0 : len;

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      st          <= S_IDLE;
      word        <= '0;
      eof_q       <= 1'b0;
      err         <= 1'b0;
      len         <= '0;
      tid         <= '0;
      wr_en       <= 1'b0;
      din         <= '0;
      ev_busy     <= 1'b0;
      events_sent <= '0;
    end else begin
      wr_en <= 1'b0;
      unique case (st)
        S_IDLE, S_OPEN: begin
          if (xfer) begin
            word  <= ev_data;
            eof_q <= ev_eof;
            if (st == S_IDLE) begin
              len     <= '0;
              ev_busy <= 1'b1;
              err     <= !ev_sof;
            end else if (ev_sof) begin
              err <= 1'b1;
            end
            // overflow: drop the word, flag the event
            if ({1'b0, len_now} == MAX_WORDS) begin
              err <= 1'b1;
              st  <= ev_eof ? S_STW_H : S_OPEN;
            end else begin
              st <= S_LO;
            end
          end
        end
        S_LO: begin
          if (!full) begin
            wr_en <= 1'b1;
            din   <= {1'b0, word[15:0]};
            st    <= S_HI;
          end
        end
        S_HI: begin
          if (!full) begin
            wr_en <= 1'b1;
            din   <= {1'b0, word[31:16]};
            len   <= len + 19'd1;
            st    <= eof_q ? S_STW_H : S_OPEN;
          end
        end
        S_STW_H: begin
          if (!full) begin
            wr_en <= 1'b1;
            din   <= {1'b1, dtstw[31:16]};
            st    <= S_STW_L;
          end
        end
        S_STW_L: begin
          if (!full) begin
            wr_en       <= 1'b1;
            din         <= {1'b1, dtstw[15:0]};
            tid         <= tid + 4'd1;
            events_sent <= events_sent + 16'd1;
            ev_busy     <= 1'b0;
            st          <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddl_event_packer.sv
// Bench for ddl_event_packer: event-level reference model with a
// per-cycle scoreboard, directed events and a randomized run.
module tb_ddl_event_packer;

  localparam logic [19:0] MAXW = 20'd4;

  logic        wr_clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ev_data = '0;
  logic        ev_valid = 1'b0;
  logic        ev_sof = 1'b0;
  logic        ev_eof = 1'b0;
  logic        full = 1'b0;
  logic        prog_full = 1'b0;
  logic        ev_ready;
  logic        wr_en;
  logic [16:0] din;
  logic        ev_busy;
  logic [15:0] events_sent;

  always #5 wr_clk = ~wr_clk;

  ddl_event_packer #(
    .MAX_WORDS(MAXW),
    .STW_ID(8'h82)
  ) dut (
    .wr_clk(wr_clk),
    .reset(reset),
    .ev_data(ev_data),
    .ev_valid(ev_valid),
    .ev_sof(ev_sof),
    .ev_eof(ev_eof),
    .ev_ready(ev_ready),
    .wr_en(wr_en),
    .din(din),
    .full(full),
    .prog_full(prog_full),
    .ev_busy(ev_busy),
    .events_sent(events_sent)
  );

  typedef struct {
    logic [16:0] d;
    bit          last;
  } ent_t;

  ent_t        q[$];
  logic [16:0] log_q[$];
  logic [16:0] lit[$];
  int          vecs = 0;
  int          errs = 0;

  bit          m_open = 0;
  bit          m_err = 0;
  int          m_len = 0;
  int          m_tid = 0;
  int          m_sent = 0;
  logic [16:0] prev_din = '0;
  bit          edge_full = 0;

  bit          v = 0, s = 0, e = 0, f = 0, pf = 0;
  logic [31:0] d = '0;
  bit          acc = 0;
  bit          rnd = 0;
  bit          arm_hold = 0;
  int          hold_cnt = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void push(logic [16:0] w, bit l);
    ent_t t;
    t.d = w;
    t.last = l;
    q.push_back(t);
  endfunction

  // event-level model: FIFO words an accepted input word must produce
  function automatic void model_accept();
    logic [31:0] dt;
    if (!m_open) begin
      m_open = 1;
      m_len = 0;
      m_err = !s;
    end else if (s) begin
      m_err = 1;
    end
    if (m_len == int'(MAXW)) begin
      m_err = 1;
    end else begin
      push({1'b0, d[15:0]}, 0);
      push({1'b0, d[31:16]}, 0);
      m_len++;
    end
    if (e) begin
      dt = (m_err ? 32'h8000_0000 : 32'h0)
         + (32'(m_len) * 32'h1000)
         + (32'(m_tid) * 32'h100) + 32'h82;
      push({1'b1, dt[31:16]}, 0);
      push({1'b1, dt[15:0]}, 1);
      m_tid = (m_tid + 1) % 16;
      m_open = 0;
    end
  endfunction

  task automatic check_cycle();
    if (wr_en) begin
      chk("wr_en_while_full", 32'(edge_full), 0);
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL spurious_write: got din %h expected no write",
                 din);
      end else begin
        chk("din", 32'(din), 32'(q[0].d));
        if (q[0].last) m_sent++;
        log_q.push_back(din);
        void'(q.pop_front());
      end
    end else begin
      chk("din_hold", 32'(din), 32'(prev_din));
    end
    prev_din = din;
    chk("ev_ready", 32'(ev_ready),
        32'(q.size() == 0 && !prog_full));
    chk("ev_busy", 32'(ev_busy), 32'(m_open || q.size() != 0));
    chk("events_sent", 32'(events_sent), 32'(16'(m_sent)));
  endtask

  task automatic tick();
    @(negedge wr_clk);
    check_cycle();
    if (rnd) begin
      f  = ($urandom_range(0, 4) == 0);
      pf = ($urandom_range(0, 6) == 0);
    end
    if (arm_hold && q.size() == 1 && q[0].d[16] == 1'b0) begin
      hold_cnt = 5;
      arm_hold = 0;
    end
    edge_full = (hold_cnt > 0) ? 1'b1 : f;
    if (hold_cnt > 0) hold_cnt--;
    full      = edge_full;
    prog_full = pf;
    ev_valid  = v;
    ev_data   = d;
    ev_sof    = s;
    ev_eof    = e;
    acc = v && q.size() == 0 && !pf;
    if (acc) model_accept();
  endtask

  task automatic send_word(logic [31:0] dw, bit sf, bit ef);
    v = 1;
    d = dw;
    s = sf;
    e = ef;
    acc = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (acc) break;
    end
    if (!acc) begin
      vecs++;
      errs++;
      $display("FAIL accept_timeout: got no transfer expected one");
    end
    v = 0;
    s = 0;
    e = 0;
  endtask

  task automatic drain();
    v = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (q.size() == 0 && hold_cnt == 0) break;
    end
    chk("drain_left", 32'(q.size()), 0);
  endtask

  task automatic check_log(string nm);
    chk({nm, "_count"}, 32'(log_q.size()), 32'(lit.size()));
    for (int i = 0; i < lit.size(); i++) begin
      if (i < log_q.size())
        chk($sformatf("%s[%0d]", nm, i), 32'(log_q[i]), 32'(lit[i]));
    end
    log_q.delete();
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge wr_clk);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_din", 32'(din), 0);
    chk("rst_busy", 32'(ev_busy), 0);
    chk("rst_sent", 32'(events_sent), 0);
    chk("rst_ready", 32'(ev_ready), 0);
    reset = 0;
    tick();

    // 3-word event with full held while the high word is due
    log_q.delete();
    arm_hold = 1;
    send_word(32'h1111_2222, 1, 0);
    send_word(32'h3333_4444, 0, 0);
    send_word(32'h5555_6666, 0, 1);
    drain();
    lit = '{17'h02222, 17'h01111, 17'h04444, 17'h03333,
            17'h06666, 17'h05555, 17'h10000, 17'h13082};
    check_log("ev3");
    chk("ev3_sent", 32'(events_sent), 1);

    // single-word event, tid 1
    send_word(32'hDEAD_BEEF, 1, 1);
    drain();
    lit = '{17'h0BEEF, 17'h0DEAD, 17'h10000, 17'h11182};
    check_log("single");

    // prog_full blocks a transfer while the event is open
    send_word(32'h0102_0304, 1, 0);
    drain();
    pf = 1;
    v = 1;
    d = 32'hAAAA_5555;
    s = 0;
    e = 1;
    repeat (3) tick();
    chk("pfull_no_xfer", 32'(q.size()), 0);
    pf = 0;
    tick();
    chk("pfull_release_xfer", 32'(acc), 1);
    v = 0;
    e = 0;
    drain();
    lit = '{17'h00304, 17'h00102, 17'h05555, 17'h0AAAA,
            17'h10000, 17'h12282};
    check_log("pfull");

    // missing SOF flags err
    send_word(32'h1234_5678, 0, 0);
    send_word(32'h9ABC_DEF0, 0, 1);
    drain();
    lit = '{17'h05678, 17'h01234, 17'h0DEF0, 17'h09ABC,
            17'h18000, 17'h12382};
    check_log("nosof");

    // overflow past MAXW words
    for (int i = 1; i <= 6; i++)
      send_word((32'(i) << 16) | (32'(i) + 32'h10), i == 1, i == 6);
    drain();
    lit = '{17'h00011, 17'h00001, 17'h00012, 17'h00002,
            17'h00013, 17'h00003, 17'h00014, 17'h00004,
            17'h18000, 17'h14482};
    check_log("ovf");
    chk("ovf_sent", 32'(events_sent), 5);

    // reset mid-event while a write is on the bus
    send_word(32'hCAFE_F00D, 1, 0);
    tick();
    tick();
    chk("pre_rst_wr_en", 32'(wr_en), 1);
    reset = 1;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_din", 32'(din), 0);
    chk("mid_rst_busy", 32'(ev_busy), 0);
    chk("mid_rst_sent", 32'(events_sent), 0);
    chk("mid_rst_ready", 32'(ev_ready), 0);
    q.delete();
    log_q.delete();
    m_open = 0;
    m_tid = 0;
    m_sent = 0;
    prev_din = '0;
    hold_cnt = 0;
    repeat (2) @(negedge wr_clk);
    reset = 0;
    tick();
    chk("post_rst_ready", 32'(ev_ready), 1);

    // randomized events
    rnd = 1;
    for (int ev = 0; ev < 150; ev++) begin
      int nw;
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        bit sf;
        sf = (w == 0) ? ($urandom_range(0, 9) != 0)
                      : ($urandom_range(0, 9) == 0);
        send_word($urandom, sf, w == nw - 1);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    rnd = 0;
    f = 0;
    pf = 0;
    drain();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
